// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_if
//  Brief    : Bundle of EXE/MEM latch, dcache, redirect and MEM/WB signals
//             around the MEM pipeline stage.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_stage_if;
   logic [31:0] imemaddr_mem;
   logic [31:0] imemload_mem;
   logic [31:0] presult_mem;
   logic [31:0] dmemstore;
   logic [31:0] imm_mem;
   logic        zero_mem;
   logic        branch_mem;
   logic        jal_mem;
   logic        jalr_mem;
   logic        lui_mem;
   logic        auipc_mem;
   logic        dmemr_mem;
   logic        dmemw_mem;
   logic        WEN_mem;
   logic        memtoreg_mem;
   logic        halt_mem;
   logic        ihit;
   logic        dhit;
   logic [31:0] dmemload;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore_o;
   logic        mem_stall;
   logic        npc_sel;
   logic [31:0] npc_target;
   logic        flush_req;
   logic [31:0] wdat_wb;
   logic [4:0]  wsel_wb;
   logic        WEN_wb;
   logic        halt_wb;
   logic [31:0] stall_count;

   // The MEM stage itself.
   modport slave (
      input  imemaddr_mem, imemload_mem, presult_mem, dmemstore, imm_mem,
      input  zero_mem, branch_mem, jal_mem, jalr_mem, lui_mem, auipc_mem,
      input  dmemr_mem, dmemw_mem, WEN_mem, memtoreg_mem, halt_mem,
      input  ihit, dhit, dmemload,
      output dmemREN, dmemWEN, dmemaddr, dmemstore_o, mem_stall,
      output npc_sel, npc_target, flush_req,
      output wdat_wb, wsel_wb, WEN_wb, halt_wb, stall_count
   );

   // Surrounding pipeline, cache and hazard logic.
   modport master (
      output imemaddr_mem, imemload_mem, presult_mem, dmemstore, imm_mem,
      output zero_mem, branch_mem, jal_mem, jalr_mem, lui_mem, auipc_mem,
      output dmemr_mem, dmemw_mem, WEN_mem, memtoreg_mem, halt_mem,
      output ihit, dhit, dmemload,
      input  dmemREN, dmemWEN, dmemaddr, dmemstore_o, mem_stall,
      input  npc_sel, npc_target, flush_req,
      input  wdat_wb, wsel_wb, WEN_wb, halt_wb, stall_count
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage
//  Brief    : RISC-V MEM stage: dcache handshake, branch/jump resolve, MEM/WB
//             latch. Optional MEM_STAGE_STALLCNT_EN adds a stall-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
   parameter logic [31:0] PC_INC = 32'd4
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_stage_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] c_jalr_mask = ~32'h1;

   state_t      r_state;
   state_t      w_state_next;
   logic [31:0] r_load_buf;
   logic [31:0] r_wdat_wb;
   logic [4:0]  r_wsel_wb;
   logic        r_wen_wb;
   logic        r_halt_wb;

   logic        w_memop;
   logic        w_ren;
   logic        w_wen;
   logic        w_mem_stall;
   logic        w_buf_load;
   logic        w_advance;
   logic        w_commit;
   logic [31:0] w_load_data;
   logic [31:0] w_pc_link;
   logic [31:0] w_pc_imm;
   logic [31:0] w_wdat;
   logic        w_unused;

   assign w_memop   = bus.dmemr_mem | bus.dmemw_mem;
   assign w_advance = bus.ihit & ~w_mem_stall;
   assign w_commit  = w_advance & ~r_halt_wb;
   assign w_unused  = ^{bus.imemload_mem[31:12], bus.imemload_mem[6:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Once halted the stage goes quiet: no requests, no stall, no commits.
   always_comb begin
      w_state_next = r_state;
      w_ren        = 1'b0;
      w_wen        = 1'b0;
      w_mem_stall  = 1'b0;
      w_buf_load   = 1'b0;
      if (r_halt_wb) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE, WAIT: begin
               w_ren = bus.dmemr_mem;
               w_wen = bus.dmemw_mem;
               if (!w_memop) begin
                  w_state_next = IDLE;
               end else if (!bus.dhit) begin
                  w_mem_stall  = 1'b1;
                  w_state_next = WAIT;
               end else if (bus.ihit) begin
                  w_state_next = IDLE;
               end else begin
                  w_buf_load   = 1'b1;
                  w_state_next = DONE;
               end
            end
            DONE: begin
               if (bus.ihit) begin
                  w_state_next = IDLE;
               end
            end
            default: begin
               w_state_next = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_load_buf <= 32'h0;
      end else if (w_buf_load) begin
         r_load_buf <= bus.dmemload;
      end
   end

   assign w_load_data = (r_state == DONE) ? r_load_buf : bus.dmemload;
   assign w_pc_link   = bus.imemaddr_mem + PC_INC;
   assign w_pc_imm    = bus.imemaddr_mem + bus.imm_mem;

   always_comb begin
      w_wdat = bus.presult_mem;
      if (bus.memtoreg_mem) begin
         w_wdat = w_load_data;
      end else if (bus.jal_mem | bus.jalr_mem) begin
         w_wdat = w_pc_link;
      end else if (bus.lui_mem) begin
         w_wdat = bus.imm_mem;
      end else if (bus.auipc_mem) begin
         w_wdat = w_pc_imm;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wdat_wb <= 32'h0;
         r_wsel_wb <= 5'd0;
         r_wen_wb  <= 1'b0;
         r_halt_wb <= 1'b0;
      end else if (w_commit) begin
         r_wdat_wb <= w_wdat;
         r_wsel_wb <= bus.imemload_mem[11:7];
         r_wen_wb  <= bus.WEN_mem;
         r_halt_wb <= r_halt_wb | bus.halt_mem;
      end
   end

   // Cache strobes are gated by reset so an in-flight request drops at once.
   assign bus.dmemREN     = w_ren & rst_n;
   assign bus.dmemWEN     = w_wen & rst_n;
   assign bus.dmemaddr    = bus.presult_mem;
   assign bus.dmemstore_o = bus.dmemstore;
   assign bus.mem_stall   = w_mem_stall;

   assign bus.npc_sel    = bus.jal_mem | bus.jalr_mem | (bus.branch_mem & bus.zero_mem);
   assign bus.npc_target = bus.jalr_mem ? (bus.presult_mem & c_jalr_mask) : w_pc_imm;
   assign bus.flush_req  = bus.npc_sel & w_advance;

   assign bus.wdat_wb = r_wdat_wb;
   assign bus.wsel_wb = r_wsel_wb;
   assign bus.WEN_wb  = r_wen_wb;
   assign bus.halt_wb = r_halt_wb;

`ifdef MEM_STAGE_STALLCNT_EN
   logic [31:0] r_stall_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_count <= 32'h0;
      end else if (w_mem_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end
   end

   assign bus.stall_count = r_stall_count;
`else
   assign bus.stall_count = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage
//  Brief    : Directed bench for mem_stage; write-back results are scored
//             against an expectation queue on every pipeline advance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

   typedef struct packed {
      logic [31:0] wdat;
      logic [4:0]  wsel;
      logic        wen;
      logic        halt;
   } wb_t;

   logic   clk;
   logic   rst_n;
   int     checks;
   int     errors;
   wb_t    exp_q[$];
   logic [31:0] stall_model;

   mem_stage_if bus();

   mem_stage #(.PC_INC(32'd4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input logic [31:0] wdat, input logic [4:0] wsel, input logic wen,
                       input logic halt);
      wb_t e;
      e.wdat = wdat; e.wsel = wsel; e.wen = wen; e.halt = halt;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clear_in();
      bus.imemaddr_mem = 32'h0; bus.imemload_mem = 32'h0; bus.presult_mem = 32'h0;
      bus.dmemstore = 32'h0; bus.imm_mem = 32'h0; bus.dmemload = 32'h0;
      bus.zero_mem = 1'b0; bus.branch_mem = 1'b0; bus.jal_mem = 1'b0; bus.jalr_mem = 1'b0;
      bus.lui_mem = 1'b0; bus.auipc_mem = 1'b0; bus.dmemr_mem = 1'b0; bus.dmemw_mem = 1'b0;
      bus.WEN_mem = 1'b0; bus.memtoreg_mem = 1'b0; bus.halt_mem = 1'b0;
      bus.ihit = 1'b0; bus.dhit = 1'b0;
   endtask

   task automatic instr(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] pres,
                        input logic [31:0] imm);
      clear_in();
      bus.imemaddr_mem = pc;
      bus.imemload_mem = {20'h0, rd, 7'h0};
      bus.presult_mem  = pres;
      bus.imm_mem      = imm;
   endtask

   // Scoreboard monitor: every advancing edge must match the next expectation.
   initial begin
      wb_t e;
      wb_t act;
      forever begin
         @(posedge clk);
         if (rst_n && bus.ihit && !bus.mem_stall) begin
            #1;
            act = {bus.wdat_wb, bus.wsel_wb, bus.WEN_wb, bus.halt_wb};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL commit_unexpected: got %h expected none", act);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL commit: got wdat=%h wsel=%0d wen=%b halt=%b expected wdat=%h wsel=%0d wen=%b halt=%b",
                           act.wdat, act.wsel, act.wen, act.halt, e.wdat, e.wsel, e.wen, e.halt);
               end
            end
         end
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_model <= 32'h0;
      end else if (bus.mem_stall) begin
         stall_model <= stall_model + 32'd1;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      clear_in();
      bus.dmemr_mem = 1'b1;
      settle();
      chk("reset_ren", {31'h0, bus.dmemREN}, 32'h0);
      step();
      step();
      chk("reset_wdat", bus.wdat_wb, 32'h0);
      chk("reset_wsel", {27'h0, bus.wsel_wb}, 32'h0);
      chk("reset_wen", {31'h0, bus.WEN_wb}, 32'h0);
      chk("reset_halt", {31'h0, bus.halt_wb}, 32'h0);
      chk("reset_stallcnt", bus.stall_count, 32'h0);
      rst_n = 1'b1;
      clear_in();
      step();

      // lw x5, 0x100: stalls two cycles, dhit+ihit on the third
      for (int c = 1; c <= 3; c++) begin
         instr(32'h10, 5'd5, 32'h100, 32'h0);
         bus.dmemr_mem = 1'b1; bus.memtoreg_mem = 1'b1; bus.WEN_mem = 1'b1;
         bus.dmemload = 32'hDEADBEEF; bus.ihit = 1'b1; bus.dhit = (c == 3);
         settle();
         chk("lw_ren", {31'h0, bus.dmemREN}, 32'h1);
         chk("lw_stall", {31'h0, bus.mem_stall}, (c < 3) ? 32'h1 : 32'h0);
         if (c == 1) chk("lw_addr", bus.dmemaddr, 32'h100);
         if (c == 3) push(32'hDEADBEEF, 5'd5, 1'b1, 1'b0);
         step();
      end
      clear_in();

      // sw 0x200: dhit cycle 2, ihit cycle 4
      for (int c = 1; c <= 4; c++) begin
         instr(32'h14, 5'd0, 32'h200, 32'h0);
         bus.dmemw_mem = 1'b1; bus.dmemstore = 32'hCAFEF00D;
         bus.dhit = (c == 2); bus.ihit = (c == 4);
         settle();
         chk("sw_wen", {31'h0, bus.dmemWEN}, (c <= 2) ? 32'h1 : 32'h0);
         chk("sw_stall", {31'h0, bus.mem_stall}, (c == 1) ? 32'h1 : 32'h0);
         if (c == 1) chk("sw_store", bus.dmemstore_o, 32'hCAFEF00D);
         if (c == 4) push(32'h200, 5'd0, 1'b0, 1'b0);
         step();
      end
      clear_in();

      // lw whose data arrives before the pipeline advances
      for (int c = 1; c <= 3; c++) begin
         instr(32'h20, 5'd7, 32'h300, 32'h0);
         bus.dmemr_mem = 1'b1; bus.memtoreg_mem = 1'b1; bus.WEN_mem = 1'b1;
         bus.dmemload = (c == 1) ? 32'h12345678 : 32'h0;
         bus.dhit = (c == 1); bus.ihit = (c == 3);
         settle();
         if (c > 1) chk("lwbuf_ren", {31'h0, bus.dmemREN}, 32'h0);
         if (c == 3) push(32'h12345678, 5'd7, 1'b1, 1'b0);
         step();
      end
      clear_in();

      // jal PC 0x40 imm 0x20 rd=1
      instr(32'h40, 5'd1, 32'h0, 32'h20);
      bus.jal_mem = 1'b1; bus.WEN_mem = 1'b1;
      settle();
      chk("jal_sel", {31'h0, bus.npc_sel}, 32'h1);
      chk("jal_target", bus.npc_target, 32'h60);
      chk("jal_noflush", {31'h0, bus.flush_req}, 32'h0);
      bus.ihit = 1'b1;
      settle();
      chk("jal_flush", {31'h0, bus.flush_req}, 32'h1);
      push(32'h44, 5'd1, 1'b1, 1'b0);
      step();

      // jalr presult 0x81
      instr(32'h50, 5'd3, 32'h81, 32'h0);
      bus.jalr_mem = 1'b1; bus.WEN_mem = 1'b1; bus.ihit = 1'b1;
      settle();
      chk("jalr_target", bus.npc_target, 32'h80);
      push(32'h54, 5'd3, 1'b1, 1'b0);
      step();

      // branch taken / not taken
      instr(32'h100, 5'd0, 32'h0, 32'hFFFF_FFF0);
      bus.branch_mem = 1'b1; bus.zero_mem = 1'b1;
      settle();
      chk("br_taken_sel", {31'h0, bus.npc_sel}, 32'h1);
      chk("br_taken_target", bus.npc_target, 32'hF0);
      bus.zero_mem = 1'b0;
      settle();
      chk("br_nottaken_sel", {31'h0, bus.npc_sel}, 32'h0);

      // lui, auipc (with wrap), jal over lui priority
      instr(32'h60, 5'd9, 32'h5, 32'hABCDE000);
      bus.lui_mem = 1'b1; bus.WEN_mem = 1'b1; bus.ihit = 1'b1;
      push(32'hABCDE000, 5'd9, 1'b1, 1'b0);
      step();
      instr(32'h1000, 5'd10, 32'h5, 32'h2000);
      bus.auipc_mem = 1'b1; bus.WEN_mem = 1'b1; bus.ihit = 1'b1;
      push(32'h3000, 5'd10, 1'b1, 1'b0);
      step();
      instr(32'hFFFF_FFF0, 5'd11, 32'h5, 32'h20);
      bus.auipc_mem = 1'b1; bus.WEN_mem = 1'b1; bus.ihit = 1'b1;
      push(32'h10, 5'd11, 1'b1, 1'b0);
      step();
      instr(32'h70, 5'd12, 32'h5, 32'h999);
      bus.lui_mem = 1'b1; bus.jal_mem = 1'b1; bus.WEN_mem = 1'b1; bus.ihit = 1'b1;
      push(32'h74, 5'd12, 1'b1, 1'b0);
      step();
      clear_in();

      // reset while waiting on the cache
      instr(32'h80, 5'd4, 32'h400, 32'h0);
      bus.dmemr_mem = 1'b1; bus.memtoreg_mem = 1'b1; bus.WEN_mem = 1'b1;
      settle();
      chk("wait_ren", {31'h0, bus.dmemREN}, 32'h1);
      step();
      rst_n = 1'b0;
      #1;
      chk("rstwait_ren", {31'h0, bus.dmemREN}, 32'h0);
      chk("rstwait_wdat", bus.wdat_wb, 32'h0);
      chk("rstwait_wsel", {27'h0, bus.wsel_wb}, 32'h0);
      chk("rstwait_wen", {31'h0, bus.WEN_wb}, 32'h0);
      step();
      rst_n = 1'b1;

      // reset while holding buffered data: next access must see IDLE
      bus.dhit = 1'b1; bus.dmemload = 32'h77;
      settle();
      step();
      bus.dhit = 1'b0;
      settle();
      chk("done_ren", {31'h0, bus.dmemREN}, 32'h0);
      rst_n = 1'b0;
      #1;
      step();
      rst_n = 1'b1;
      settle();
      chk("rstdone_idle_ren", {31'h0, bus.dmemREN}, 32'h1);
      clear_in();
      step();

      // halt is sticky and silences the stage
      instr(32'h90, 5'd2, 32'h55, 32'h0);
      bus.halt_mem = 1'b1; bus.WEN_mem = 1'b1; bus.ihit = 1'b1;
      push(32'h55, 5'd2, 1'b1, 1'b1);
      step();
      instr(32'h94, 5'd4, 32'h66, 32'h0);
      bus.WEN_mem = 1'b1; bus.dmemr_mem = 1'b1; bus.dmemw_mem = 1'b1; bus.ihit = 1'b1;
      settle();
      chk("halt_ren", {31'h0, bus.dmemREN}, 32'h0);
      chk("halt_wen", {31'h0, bus.dmemWEN}, 32'h0);
      push(32'h55, 5'd2, 1'b1, 1'b1);
      step();
      clear_in();
      step();

`ifdef MEM_STAGE_STALLCNT_EN
      chk("stall_count", bus.stall_count, stall_model);
`else
      chk("stall_count", bus.stall_count, 32'h0);
`endif
      chk("queue_empty", exp_q.size(), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
